// File: rtl/bp_pkg.sv
// Shared constants, state encoding and address helper for the backprop layer sequencer.
package bp_pkg;

  localparam int BP_WEIGHTS   = 33;
  localparam int BP_DENDRITES = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_STORE,
    S_DONE
  } bp_state_t;

  function automatic int bp_base_addr(input int n);
    return n * BP_WEIGHTS;
  endfunction

endpackage

// File: rtl/bp_grad_accum.sv
// Bank of 32 real accumulators: clear on a new layer pass, add one engine change vector per neuron.
module bp_grad_accum
  import bp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic add,
  input  real  delta [BP_DENDRITES-1:0],
  output real  acc   [BP_DENDRITES-1:0]
);

  for (genvar gi = 0; gi < BP_DENDRITES; gi++) begin : g_acc
    real acc_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_reg <= 0.0;
      end else if (clear) begin
        acc_reg <= 0.0;
      end else if (add) begin
        acc_reg <= acc_reg + delta[gi];
      end
    end

    assign acc[gi] = acc_reg;
  end

endmodule

// File: rtl/bp_layer_sequencer.sv
// Walks every neuron of a layer through one shared backprop engine:
// load weights, let the engine settle, write weights back, accumulate error.
module bp_layer_sequencer
  import bp_pkg::*;
#(
  parameter int NEURONS    = 8,
  parameter int ENGINE_LAT = 1,
  parameter int ADDR_W     = $clog2(NEURONS * 33)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  real               bp_axons            [NEURONS-1:0],
  input  real               bp_backprops        [NEURONS-1:0],
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  real               mem_rd_data,
  output real               mem_wr_data,
  output real               eng_weights         [BP_WEIGHTS-1:0],
  output real               eng_axon,
  output real               eng_backprop,
  input  real               eng_backprop_change [BP_DENDRITES-1:0],
  input  real               eng_weights_new     [BP_WEIGHTS-1:0],
  output real               bp_prev_backprop    [BP_DENDRITES-1:0]
);

  localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int LW = $clog2(ENGINE_LAT + 1);

  bp_state_t       state_reg;
  logic [NW-1:0]   n_reg;
  logic [5:0]      k_reg;
  logic [LW-1:0]   lat_reg;
  real             wb_buf [BP_WEIGHTS-1:0];

  logic [NW-1:0]   n_inc;
  logic            last_neuron;
  logic            last_lat;
  logic            acc_clear;
  logic            acc_add;

  assign n_inc       = n_reg + 1'b1;
  assign last_neuron = (n_reg == NW'(NEURONS - 1));
  assign last_lat    = (lat_reg == LW'(ENGINE_LAT - 1));
  assign acc_clear   = (state_reg == S_IDLE) && start;
  assign acc_add     = (state_reg == S_COMPUTE) && last_lat;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [NW-1:0] n, input logic [5:0] k);
    return ADDR_W'(bp_base_addr(int'(n)) + int'(k));
  endfunction

  // k_reg counts the cycle inside LOAD (0..33) and the weight being written inside STORE (0..32).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      n_reg        <= '0;
      k_reg        <= '0;
      lat_reg      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_addr     <= '0;
      mem_wr_data  <= 0.0;
      eng_axon     <= 0.0;
      eng_backprop <= 0.0;
      for (int i = 0; i < BP_WEIGHTS; i++) begin
        eng_weights[i] <= 0.0;
        wb_buf[i]      <= 0.0;
      end
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg    <= S_LOAD;
            busy         <= 1'b1;
            n_reg        <= '0;
            k_reg        <= '0;
            mem_rd_en    <= 1'b1;
            mem_addr     <= '0;
            eng_axon     <= bp_axons[0];
            eng_backprop <= bp_backprops[0];
          end
        end
        S_LOAD: begin
          // Read data lags the strobe by one cycle, so cycle k captures weight k-1.
          if (k_reg != 6'd0) begin
            eng_weights[k_reg - 6'd1] <= mem_rd_data;
          end
          if (k_reg < 6'd32) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= addr_of(n_reg, k_reg + 6'd1);
          end else begin
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
          end
          if (k_reg == 6'd33) begin
            state_reg <= S_COMPUTE;
            k_reg     <= '0;
            lat_reg   <= '0;
          end else begin
            k_reg <= k_reg + 6'd1;
          end
        end
        S_COMPUTE: begin
          if (last_lat) begin
            for (int i = 0; i < BP_WEIGHTS; i++) begin
              wb_buf[i] <= eng_weights_new[i];
            end
            state_reg   <= S_STORE;
            k_reg       <= '0;
            mem_wr_en   <= 1'b1;
            mem_addr    <= addr_of(n_reg, 6'd0);
            mem_wr_data <= eng_weights_new[0];
          end else begin
            lat_reg <= lat_reg + 1'b1;
          end
        end
        S_STORE: begin
          if (k_reg < 6'd32) begin
            k_reg       <= k_reg + 6'd1;
            mem_addr    <= addr_of(n_reg, k_reg + 6'd1);
            mem_wr_data <= wb_buf[k_reg + 6'd1];
          end else begin
            mem_wr_en <= 1'b0;
            k_reg     <= '0;
            if (last_neuron) begin
              state_reg <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              mem_addr  <= '0;
            end else begin
              state_reg    <= S_LOAD;
              n_reg        <= n_inc;
              mem_rd_en    <= 1'b1;
              mem_addr     <= addr_of(n_inc, 6'd0);
              eng_axon     <= bp_axons[n_inc];
              eng_backprop <= bp_backprops[n_inc];
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  bp_grad_accum u_accum (
    .clk   (clk),
    .rst   (rst),
    .clear (acc_clear),
    .add   (acc_add),
    .delta (eng_backprop_change),
    .acc   (bp_prev_backprop)
  );

endmodule

// File: tb/tb_bp_layer_sequencer.sv
// Scoreboard bench for bp_layer_sequencer in three configurations (N/LAT = 2/1, 2/3, 1/1)
// with a bench-side weight memory and engine stub.
module tb_bp_layer_sequencer;

  typedef struct {
    bit  wr;
    int  addr;
    real data;
  } strobe_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string what, input string act, input string req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %s, expected %s", what, act, req);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int NN  = (gi == 2) ? 1 : 2;
    localparam int LAT = (gi == 1) ? 3 : 1;
    localparam int AW  = $clog2(NN * 33);

    logic          rst, start, busy, done, rd_en, wr_en, preload;
    logic [AW-1:0] addr;
    real           rd_data, wr_data, eng_ax, eng_bp;
    real           axons [NN-1:0];
    real           bps   [NN-1:0];
    real           eng_w [32:0];
    real           eng_new [32:0];
    real           eng_chg [31:0];
    real           prev  [31:0];
    real           mem   [NN*33];
    real           ref_mem [NN*33];

    strobe_t exp_q[$];
    int      exp_dur_q[$];
    real     exp_pb_q[$];
    int      done_cnt = 0;
    int      rise_cyc = 0;
    int      cur_n = 0;
    int      quiet = 0;
    bit      busy_prev = 1'b0;
    bit      fin = 1'b0;

    bp_layer_sequencer #(.NEURONS(NN), .ENGINE_LAT(LAT), .ADDR_W(AW)) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .busy                (busy),
      .done                (done),
      .bp_axons            (axons),
      .bp_backprops        (bps),
      .mem_rd_en           (rd_en),
      .mem_wr_en           (wr_en),
      .mem_addr            (addr),
      .mem_rd_data         (rd_data),
      .mem_wr_data         (wr_data),
      .eng_weights         (eng_w),
      .eng_axon            (eng_ax),
      .eng_backprop        (eng_bp),
      .eng_backprop_change (eng_chg),
      .eng_weights_new     (eng_new),
      .bp_prev_backprop    (prev)
    );

    // Engine stub: combinational, so any latency >= 1 sees settled outputs.
    always_comb begin
      for (int k = 0; k < 33; k++) eng_new[k] = eng_w[k] + 1.0;
      for (int i = 0; i < 32; i++) eng_chg[i] = eng_bp * 0.5;
    end

    always @(posedge clk) begin
      if (preload) begin
        for (int a = 0; a < NN * 33; a++) mem[a] <= real'(a);
      end else begin
        if (rd_en) rd_data <= mem[int'(addr)];
        if (wr_en) mem[int'(addr)] <= wr_data;
      end
    end

    // Monitor: pops expectations whenever the DUT strobes memory or signals done.
    always @(negedge clk) begin
      strobe_t e;
      bit ok;
      if (rst) begin
        exp_q.delete();
        exp_dur_q.delete();
        exp_pb_q.delete();
        quiet = 0;
      end else begin
        if (rd_en || wr_en) begin
          check(!(rd_en && wr_en), $sformatf("cfg%0d strobe_excl", gi),
                $sformatf("rd=%0b wr=%0b", rd_en, wr_en), "one strobe");
          if (exp_q.size() == 0) begin
            check(1'b0, $sformatf("cfg%0d strobe_unexpected", gi),
                  $sformatf("wr=%0b addr=%0d", wr_en, addr), "no strobe");
          end else begin
            e = exp_q.pop_front();
            ok = (wr_en == e.wr) && (int'(addr) == e.addr) && (!e.wr || wr_data == e.data);
            check(ok, $sformatf("cfg%0d strobe", gi),
                  $sformatf("wr=%0b addr=%0d data=%0.2f", wr_en, addr, wr_data),
                  $sformatf("wr=%0b addr=%0d data=%0.2f", e.wr, e.addr, e.data));
          end
          if (rd_en) cur_n = int'(addr) / 33;
        end
        if (busy && !rd_en && !wr_en) quiet++;
        else quiet = 0;
        // quiet==1 is the capture cycle; from 2 on the engine inputs must be held.
        if (quiet >= 2) begin
          ok = (eng_ax == axons[cur_n]) && (eng_bp == bps[cur_n]);
          for (int k = 0; k < 33; k++) if (eng_w[k] != ref_mem[cur_n*33+k]) ok = 1'b0;
          check(ok, $sformatf("cfg%0d compute_hold n%0d", gi, cur_n),
                $sformatf("axon=%0.2f bp=%0.2f w0=%0.2f w32=%0.2f", eng_ax, eng_bp, eng_w[0], eng_w[32]),
                $sformatf("axon=%0.2f bp=%0.2f w0=%0.2f w32=%0.2f", axons[cur_n], bps[cur_n],
                          ref_mem[cur_n*33], ref_mem[cur_n*33+32]));
        end
        if (busy && !busy_prev) rise_cyc = cyc;
        if (done) begin
          if (exp_dur_q.size() == 0 || exp_pb_q.size() == 0) begin
            check(1'b0, $sformatf("cfg%0d done_unexpected", gi), "done pulse", "no done");
          end else begin
            int  dur;
            real pb;
            dur = exp_dur_q.pop_front();
            pb  = exp_pb_q.pop_front();
            check(cyc - rise_cyc == dur && !busy, $sformatf("cfg%0d done_timing", gi),
                  $sformatf("%0d cycles busy=%0b", cyc - rise_cyc, busy),
                  $sformatf("%0d cycles busy=0", dur));
            ok = 1'b1;
            for (int i = 0; i < 32; i++) if (prev[i] != pb) ok = 1'b0;
            check(ok, $sformatf("cfg%0d prev_backprop", gi),
                  $sformatf("p0=%0.3f p31=%0.3f", prev[0], prev[31]), $sformatf("all %0.3f", pb));
            check(exp_q.size() == 0, $sformatf("cfg%0d strobes_left", gi),
                  $sformatf("%0d", exp_q.size()), "0");
            $display("cfg%0d pass done: %0d cycles, prev_backprop=%0.3f", gi, cyc - rise_cyc, prev[0]);
          end
          done_cnt++;
        end
      end
      busy_prev = busy;
    end

    task automatic check_reset(input string tag);
      bit ok;
      ok = !busy && !done && !rd_en && !wr_en && (addr == '0) && (wr_data == 0.0) &&
           (eng_ax == 0.0) && (eng_bp == 0.0);
      for (int k = 0; k < 33; k++) if (eng_w[k] != 0.0) ok = 1'b0;
      for (int i = 0; i < 32; i++) if (prev[i] != 0.0) ok = 1'b0;
      check(ok, $sformatf("cfg%0d reset_%s", gi, tag),
            $sformatf("busy=%0b done=%0b rd=%0b wr=%0b addr=%0d wd=%0.2f ax=%0.2f w0=%0.2f p0=%0.2f",
                      busy, done, rd_en, wr_en, addr, wr_data, eng_ax, eng_w[0], prev[0]),
            "all zero");
    endtask

    task automatic check_mem(input string tag);
      bit ok;
      int bad_a;
      ok = 1'b1;
      bad_a = -1;
      for (int a = 0; a < NN * 33; a++) if (mem[a] != ref_mem[a] && ok) begin ok = 1'b0; bad_a = a; end
      check(ok, $sformatf("cfg%0d mem_%s", gi, tag),
            (bad_a < 0) ? "match" : $sformatf("mem[%0d]=%0.2f", bad_a, mem[bad_a]),
            (bad_a < 0) ? "match" : $sformatf("%0.2f", ref_mem[bad_a]));
    endtask

    task automatic do_preload();
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      for (int a = 0; a < NN * 33; a++) ref_mem[a] = real'(a);
    endtask

    // One layer pass; restart_at>0 pulses start again mid-pass, abort_at>0 resets mid-pass.
    task automatic do_pass(input int restart_at, input int abort_at);
      real pb;
      int  base, t;
      pb = 0.0;
      for (int n = 0; n < NN; n++) begin
        pb += bps[n] * 0.5;
        for (int k = 0; k < 33; k++) exp_q.push_back('{1'b0, n*33+k, 0.0});
        for (int k = 0; k < 33; k++) exp_q.push_back('{1'b1, n*33+k, ref_mem[n*33+k] + 1.0});
      end
      exp_dur_q.push_back(NN * (67 + LAT));
      exp_pb_q.push_back(pb);
      base = done_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (restart_at > 0) begin
        repeat (restart_at) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (abort_at > 0) begin
        repeat (abort_at) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("midpass");
        @(negedge clk);
        #1 rst = 1'b0;
        check_mem("after_abort");
        @(negedge clk);
      end else begin
        t = 0;
        while (done_cnt == base && t < 3000) begin
          @(negedge clk);
          t++;
        end
        check(done_cnt != base, $sformatf("cfg%0d done_wait", gi), "timeout", "done pulse");
        for (int a = 0; a < NN * 33; a++) ref_mem[a] += 1.0;
        repeat (5) @(negedge clk);
        check(done_cnt == base + 1, $sformatf("cfg%0d done_count", gi),
              $sformatf("%0d", done_cnt - base), "1");
        check_mem("after_pass");
      end
    endtask

    task automatic rand_inputs();
      for (int n = 0; n < NN; n++) begin
        axons[n] = real'(int'($urandom_range(0, 100))) / 4.0;
        bps[n]   = (real'(int'($urandom_range(0, 40))) - 20.0) / 4.0;
      end
    endtask

    initial begin
      rst = 1'b1;
      start = 1'b0;
      preload = 1'b0;
      rand_inputs();
      @(negedge clk);
      do_preload();
      check_reset("initial");
      rst = 1'b0;
      @(negedge clk);
      // Directed pass: backprops {2,4} for two-neuron configs, {-2} for the single neuron.
      for (int n = 0; n < NN; n++) bps[n] = (NN == 1) ? -2.0 : 2.0 * real'(n + 1);
      do_pass(0, 0);
      // Identical pass with a stray start at cycle 10 of the pass.
      do_preload();
      do_pass(10, 0);
      // Reset during COMPUTE of neuron 0, then a fresh pass.
      rand_inputs();
      do_pass(0, 34 + LAT / 2);
      do_pass(0, 0);
      for (int r = 0; r < 2; r++) begin
        rand_inputs();
        do_pass(0, 0);
      end
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    check(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin, "overall_timeout", "not finished", "finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
